// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, minimum bit period and the
// receiver/transmitter state encodings used by both halves of the link.
package uart_pkg;

    localparam int DATA_BITS         = 8;
    localparam int MIN_CLOCK_PER_BIT = 4;
    localparam int CPB_W             = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Last timer value of the first half bit; the start bit is checked here.
    function automatic logic [CPB_W-1:0] half_bit_last(input logic [CPB_W-1:0] cpb);
        return (cpb >> 1) - CPB_W'(1);
    endfunction

    function automatic logic [CPB_W-1:0] full_bit_last(input logic [CPB_W-1:0] cpb);
        return cpb - CPB_W'(1);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx pad; resets to the idle
// (high) line level so a reset never looks like a start bit.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with runtime bit period, mid-bit sampling, glitch reject
// on the start bit and framing-error detection with break hold-off.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          clock_per_bit,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_done_tick_o,
    output logic                 frame_err_o,
    output logic                 rx_busy_o
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t            state_reg, state_next;
    logic [15:0]          cpb_reg, cpb_next;
    logic [15:0]          bit_timer_reg, bit_timer_next;
    logic [CNT_W-1:0]     bit_counter_reg, bit_counter_next;
    logic [DATA_BITS-1:0] shreg_reg, shreg_next;
    logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
    logic                 done_tick_reg, done_tick_next;
    logic                 frame_err_reg, frame_err_next;

    logic half_hit;
    logic full_hit;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_i),
        .q   (rx_s)
    );

    assign half_hit = (bit_timer_reg == half_bit_last(cpb_reg));
    assign full_hit = (bit_timer_reg == full_bit_last(cpb_reg));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cpb_reg         <= '0;
            bit_timer_reg   <= '0;
            bit_counter_reg <= '0;
            shreg_reg       <= '0;
            rx_data_reg     <= '0;
            done_tick_reg   <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cpb_reg         <= cpb_next;
            bit_timer_reg   <= bit_timer_next;
            bit_counter_reg <= bit_counter_next;
            shreg_reg       <= shreg_next;
            rx_data_reg     <= rx_data_next;
            done_tick_reg   <= done_tick_next;
            frame_err_reg   <= frame_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cpb_next         = cpb_reg;
        bit_timer_next   = bit_timer_reg;
        bit_counter_next = bit_counter_reg;
        shreg_next       = shreg_reg;
        rx_data_next     = rx_data_reg;
        done_tick_next   = 1'b0;
        frame_err_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next     = START;
                    cpb_next       = clock_per_bit;
                    bit_timer_next = '0;
                end
            end

            START: begin
                if (half_hit) begin
                    bit_timer_next = '0;
                    // A line already back high at mid start bit was only a glitch.
                    state_next     = rx_s ? IDLE : DATA;
                end else begin
                    bit_timer_next = bit_timer_reg + 16'd1;
                end
            end

            DATA: begin
                if (full_hit) begin
                    shreg_next     = {rx_s, shreg_reg[DATA_BITS-1:1]};
                    bit_timer_next = '0;
                    if (bit_counter_reg == LAST_BIT) begin
                        bit_counter_next = '0;
                        state_next       = STOP;
                    end else begin
                        bit_counter_next = bit_counter_reg + CNT_W'(1);
                    end
                end else begin
                    bit_timer_next = bit_timer_reg + 16'd1;
                end
            end

            STOP: begin
                if (full_hit) begin
                    bit_timer_next = '0;
                    if (rx_s) begin
                        rx_data_next   = shreg_reg;
                        done_tick_next = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = BREAK;
                    end
                end else begin
                    bit_timer_next = bit_timer_reg + 16'd1;
                end
            end

            BREAK: begin
                // Hold off until the line idles so a stuck-low line is one error, not many.
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx_data_o      = rx_data_reg;
    assign rx_done_tick_o = done_tick_reg;
    assign frame_err_o    = frame_err_reg;
    assign rx_busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// checked against an expected-event queue built from the transmitted frames.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] clock_per_bit;
    logic        rx_i;
    logic [7:0]  rx_data_o;
    logic        rx_done_tick_o;
    logic        frame_err_o;
    logic        rx_busy_o;

    uart_rx #(
        .SYNC_STAGES (2),
        .DATA_BITS   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clock_per_bit  (clock_per_bit),
        .rx_i           (rx_i),
        .rx_data_o      (rx_data_o),
        .rx_done_tick_o (rx_done_tick_o),
        .frame_err_o    (frame_err_o),
        .rx_busy_o      (rx_busy_o)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int unsigned fall_cyc = 0;
    int unsigned tick_cyc = 0;

    // Expected event stream: bit 8 = framing error, bits 7:0 = rx_data_o at the event.
    logic [8:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every tick or error pulse must match the next expected event.
    always @(negedge clk) begin
        logic [8:0] ev;
        if (rst === 1'b0 && (rx_done_tick_o === 1'b1 || frame_err_o === 1'b1)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_event: observed tick=%b err=%b data=%0h expected no event",
                       rx_done_tick_o, frame_err_o, rx_data_o);
            end else begin
                ev = exp_q.pop_front();
                check("event_kind", 32'({rx_done_tick_o, frame_err_o}), ev[8] ? 32'h1 : 32'h2);
                check("event_data", 32'(rx_data_o), 32'(ev[7:0]));
                if (!ev[8]) tick_cyc = cyc;
                $display("event: %s data=%02h", ev[8] ? "frame_err" : "rx_done", rx_data_o);
            end
        end
    end

    // Drives one 8N1 frame starting at a negedge; bit period of the frame is cpb,
    // while clock_per_bit is switched to cpb_after in the middle of the data bits.
    task automatic send(input logic [7:0] data, input int cpb, input bit stop_ok, input int cpb_after);
        if (stop_ok) begin
            last_good = data;
            exp_q.push_back({1'b0, data});
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        clock_per_bit = 16'(cpb);
        rx_i     = 1'b0;
        fall_cyc = cyc;
        repeat (cpb) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            rx_i = data[b];
            if (b == 4) clock_per_bit = 16'(cpb_after);
            repeat (cpb) @(negedge clk);
        end
        rx_i = stop_ok;
        repeat (cpb) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int          cpb;
        int          cpb2;
        logic [7:0]  d;
        bit          ok;
        int unsigned lat;
        logic [7:0]  b2b [4];

        rst           = 1'b1;
        rx_i          = 1'b1;
        clock_per_bit = 16'd868;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(rx_data_o), 32'h0);
        check("reset_tick", 32'(rx_done_tick_o), 32'h0);
        check("reset_err",  32'(frame_err_o), 32'h0);
        check("reset_busy", 32'(rx_busy_o), 32'h0);
        rst = 1'b0;
        idle(5);

        // Slow baud single byte, including start-to-tick latency.
        send(8'hA5, 868, 1'b1, 868);
        idle(10);
        lat = tick_cyc - fall_cyc;
        check("latency_868", 32'(lat >= 32'd8248 && lat <= 32'd8250), 32'h1);
        check("data_a5", 32'(rx_data_o), 32'hA5);
        check("idle_after_a5", 32'(rx_busy_o), 32'h0);

        // Back-to-back frames with a single stop bit.
        b2b = '{8'h00, 8'hFF, 8'h55, 8'h80};
        for (int i = 0; i < 4; i++) send(b2b[i], 10, 1'b1, 10);
        idle(30);
        check("b2b_all_seen", 32'(exp_q.size()), 32'h0);
        check("b2b_last", 32'(rx_data_o), 32'h80);

        // Short low glitch on an idle line is rejected at mid start bit.
        clock_per_bit = 16'd40;
        rx_i = 1'b0;
        repeat (10) @(negedge clk);
        rx_i = 1'b1;
        repeat (5) @(negedge clk);
        check("glitch_busy", 32'(rx_busy_o), 32'h1);
        repeat (20) @(negedge clk);
        check("glitch_idle", 32'(rx_busy_o), 32'h0);
        check("glitch_data", 32'(rx_data_o), 32'h80);

        // Stop bit low: error pulse, break hold while low, then recovery.
        send(8'h3C, 20, 1'b0, 20);
        rx_i = 1'b0;
        repeat (30) @(negedge clk);
        check("break_busy", 32'(rx_busy_o), 32'h1);
        rx_i = 1'b1;
        repeat (5) @(negedge clk);
        check("break_exit", 32'(rx_busy_o), 32'h0);
        check("err_keeps_data", 32'(rx_data_o), 32'h80);
        send(8'h12, 20, 1'b1, 20);
        idle(10);
        check("data_12", 32'(rx_data_o), 32'h12);

        // Reset in the middle of the data bits aborts silently.
        clock_per_bit = 16'd20;
        rx_i = 1'b0;
        repeat (20) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            d    = 8'h77;
            rx_i = d[b];
            repeat (20) @(negedge clk);
        end
        rst  = 1'b1;
        rx_i = 1'b1;
        @(negedge clk);
        last_good = 8'h00;
        check("midrst_data", 32'(rx_data_o), 32'h0);
        check("midrst_tick", 32'(rx_done_tick_o), 32'h0);
        check("midrst_err",  32'(frame_err_o), 32'h0);
        check("midrst_busy", 32'(rx_busy_o), 32'h0);
        rst = 1'b0;
        idle(10);
        send(8'h99, 20, 1'b1, 20);
        idle(10);
        check("data_99", 32'(rx_data_o), 32'h99);

        // Bit period change during a frame only applies to the next frame.
        send(8'h5A, 20, 1'b1, 40);
        send(8'hC3, 40, 1'b1, 40);
        idle(50);
        check("cpb_change_seen", 32'(exp_q.size()), 32'h0);
        check("data_c3", 32'(rx_data_o), 32'hC3);

        // Randomized frames: random period, data, gaps, mid-frame period changes and bad stops.
        for (int i = 0; i < 24; i++) begin
            cpb  = int'($urandom_range(4, 48));
            cpb2 = int'($urandom_range(4, 48));
            d    = 8'($urandom);
            ok   = ($urandom_range(0, 4) != 0);
            send(d, cpb, ok, cpb2);
            if (!ok) begin
                rx_i = 1'b0;
                repeat ($urandom_range(0, 2 * cpb)) @(negedge clk);
                check("rand_break_busy", 32'(rx_busy_o), 32'h1);
                idle(cpb + 4);
            end else begin
                idle(int'($urandom_range(0, 2 * cpb)));
            end
        end
        idle(200);
        check("rand_all_seen", 32'(exp_q.size()), 32'h0);
        check("rand_idle", 32'(rx_busy_o), 32'h0);
        check("rand_last_data", 32'(rx_data_o), 32'(last_good));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
